instr_fetch_queue: RTL and testbench

Instruction fetch queue between the fetch stage and `instr_decode`. Buffers up to `DEPTH` fetched {PC, instruction, fetch-address-error} entries so fetch can run ahead of decode stalls. Presents the oldest entry to decode, with a defined NOP when empty. Discards all contents on a pipeline flush (exception, ERET, branch redirect).

---
 rtl/instr_fetch_queue.sv | 94 +++++++++
 tb/tb_instr_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch queue between fetch and decode
module instr_fetch_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             if_valid_i,
  input  logic [31:0]      if_instr_i,
  input  logic [31:0]      if_pc_i,
  output logic             if_ready_o,
  input  logic             id_stall_i,
  output logic             id_valid_o,
  output logic [31:0]      id_instr_o,
  output logic [31:0]      id_pc_o,
  output logic             id_adel_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef struct packed {
    logic        adel;
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push;
  logic             pop;

  // Handshake flags come only from registered occupancy, so no input reaches them combinationally.
  assign if_ready_o = (count_q != FULL_CNT);
  assign id_valid_o = (count_q != '0);
  assign count_o    = count_q;

  // A flush cycle swallows any transfer that would otherwise happen.
  assign push = if_valid_i & if_ready_o & ~flush_i;
  assign pop  = id_valid_o & ~id_stall_i & ~flush_i;

  // Head is read straight from storage; an empty queue shows a NOP at PC 0.
  assign head       = mem_q[rd_ptr_q];
  assign id_instr_o = id_valid_o ? head.instr : 32'h0000_0000;
  assign id_pc_o    = id_valid_o ? head.pc    : 32'h0000_0000;
  assign id_adel_o  = id_valid_o ? head.adel  : 1'b0;

  // Next pointer/occupancy values; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state; reset empties the queue immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is never cleared; validity is tracked solely by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{adel: (if_pc_i[1:0] != 2'b00), pc: if_pc_i, instr: if_instr_i};
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        if_valid_i;
  logic [31:0] if_instr_i;
  logic [31:0] if_pc_i;
  logic        if_ready_o;
  logic        id_stall_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_adel_o;
  logic [2:0]  count_o;

  int vectors    = 0;
  int miscompares = 0;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .if_valid_i (if_valid_i),
    .if_instr_i (if_instr_i),
    .if_pc_i    (if_pc_i),
    .if_ready_o (if_ready_o),
    .id_stall_i (id_stall_i),
    .id_valid_o (id_valid_o),
    .id_instr_o (id_instr_o),
    .id_pc_o    (id_pc_o),
    .id_adel_o  (id_adel_o),
    .count_o    (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: an ordered list of {adel, pc, instr}, oldest first.
  logic [64:0] model [$];

  typedef struct {
    logic        flush;
    logic        valid;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] pc;
    int          e_count;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_adel;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic fl, input logic v, input logic st,
                              input logic [31:0] ins, input logic [31:0] p,
                              input int ec, input logic er, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep, input logic ea);
    vec_t r;
    r.flush = fl; r.valid = v; r.stall = st; r.instr = ins; r.pc = p;
    r.e_count = ec; r.e_ready = er; r.e_valid = ev;
    r.e_instr = ei; r.e_pc = ep; r.e_adel = ea;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [64:0] h;
    h = (model.size() != 0) ? model[0] : 65'h0;
    chk({tag, " count"}, 32'(count_o),    32'(model.size()));
    chk({tag, " ready"}, 32'(if_ready_o), 32'(model.size() != DEPTH));
    chk({tag, " valid"}, 32'(id_valid_o), 32'(model.size() != 0));
    chk({tag, " instr"}, id_instr_o,      h[31:0]);
    chk({tag, " pc"},    id_pc_o,         h[63:32]);
    chk({tag, " adel"},  32'(id_adel_o),  32'(h[64]));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " count"}, 32'(count_o),    32'd0);
    chk({tag, " ready"}, 32'(if_ready_o), 32'd1);
    chk({tag, " valid"}, 32'(id_valid_o), 32'd0);
    chk({tag, " instr"}, id_instr_o,      32'd0);
    chk({tag, " pc"},    id_pc_o,         32'd0);
    chk({tag, " adel"},  32'(id_adel_o),  32'd0);
  endtask

  // Drive one cycle's inputs (called just after an edge), clock it, and update the model.
  task automatic cycle(input logic fl, input logic v, input logic st,
                       input logic [31:0] ins, input logic [31:0] p);
    bit mpush, mpop;
    flush_i = fl; if_valid_i = v; id_stall_i = st; if_instr_i = ins; if_pc_i = p;
    mpush = v && (model.size() < DEPTH) && !fl;
    mpop  = (model.size() > 0) && !st && !fl;
    @(posedge clk);
    #1;
    if (fl) model.delete();
    else begin
      if (mpop)  void'(model.pop_front());
      if (mpush) model.push_back({(p[1:0] != 2'b00), p, ins});
    end
  endtask

  initial begin
    rst = 1'b1; flush_i = 0; if_valid_i = 0; id_stall_i = 0; if_instr_i = 0; if_pc_i = 0;
    #2;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_vals("post_reset");

    //        fl v  st instr          pc             cnt rdy vld e_instr        e_pc           adel
    tbl.push_back(mk(0,1,1, 32'h2408_0001, 32'hBFC0_0000, 1, 1, 1, 32'h2408_0001, 32'hBFC0_0000, 0));
    tbl.push_back(mk(0,0,0, 32'h0,         32'h0,         0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0,1,1, 32'h11,        32'h100,       1, 1, 1, 32'h11,        32'h100,       0));
    tbl.push_back(mk(0,1,1, 32'h12,        32'h104,       2, 1, 1, 32'h11,        32'h100,       0));
    tbl.push_back(mk(0,1,1, 32'h13,        32'h108,       3, 1, 1, 32'h11,        32'h100,       0));
    tbl.push_back(mk(0,1,1, 32'h14,        32'h10C,       4, 0, 1, 32'h11,        32'h100,       0));
    tbl.push_back(mk(0,1,1, 32'h99,        32'h1F0,       4, 0, 1, 32'h11,        32'h100,       0));
    tbl.push_back(mk(0,1,0, 32'h98,        32'h1F4,       3, 1, 1, 32'h12,        32'h104,       0));
    tbl.push_back(mk(0,1,0, 32'h15,        32'h110,       3, 1, 1, 32'h13,        32'h108,       0));
    tbl.push_back(mk(0,0,0, 32'h0,         32'h0,         2, 1, 1, 32'h14,        32'h10C,       0));
    tbl.push_back(mk(0,1,1, 32'h16,        32'h114,       3, 1, 1, 32'h14,        32'h10C,       0));
    tbl.push_back(mk(1,1,0, 32'h77,        32'h200,       0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0,0,0, 32'h0,         32'h0,         0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk(0,1,1, 32'h21,        32'hBFC0_0002, 1, 1, 1, 32'h21,        32'hBFC0_0002, 1));
    tbl.push_back(mk(0,1,1, 32'h22,        32'hBFC0_0004, 2, 1, 1, 32'h21,        32'hBFC0_0002, 1));
    tbl.push_back(mk(0,0,0, 32'h0,         32'h0,         1, 1, 1, 32'h22,        32'hBFC0_0004, 0));
    tbl.push_back(mk(0,0,0, 32'h0,         32'h0,         0, 1, 0, 32'h0,         32'h0,         0));

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cycle(tbl[i].flush, tbl[i].valid, tbl[i].stall, tbl[i].instr, tbl[i].pc);
      chk({tag, " count"}, 32'(count_o),    32'(tbl[i].e_count));
      chk({tag, " ready"}, 32'(if_ready_o), 32'(tbl[i].e_ready));
      chk({tag, " valid"}, 32'(id_valid_o), 32'(tbl[i].e_valid));
      chk({tag, " instr"}, id_instr_o,      tbl[i].e_instr);
      chk({tag, " pc"},    id_pc_o,         tbl[i].e_pc);
      chk({tag, " adel"},  32'(id_adel_o),  32'(tbl[i].e_adel));
    end

    // Steady push+pop at occupancy 2; pointers wrap several times.
    cycle(0, 1, 1, 32'h300, 32'h300);
    cycle(0, 1, 1, 32'h304, 32'h304);
    chk_model("cont_fill");
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 32'h400 + 32'(i), 32'h308 + 32'(4 * i));
      chk_model($sformatf("cont%0d", i));
      chk($sformatf("cont%0d steady", i), 32'(count_o), 32'd2);
    end

    // Asynchronous reset landing mid-cycle with two entries queued.
    chk("async_pre count", 32'(count_o), 32'd2);
    if_valid_i = 1'b1; id_stall_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    model.delete();
    @(posedge clk); #1;
    chk_reset_vals("async_hold");
    rst = 1'b0;

    // Randomized traffic against the reference list.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] p;
      p = $urandom;
      if ($urandom_range(3) != 0) p[1:0] = 2'b00;
      cycle(($urandom_range(15) == 0), ($urandom_range(9) < 7), ($urandom_range(9) < 4),
            $urandom, p);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
